// File: rtl/pc_pkg.sv
// Shared encodings for the piRISC program-counter sequencer: pc_select codes and FSM states.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'b000,
        PC_BRANCH = 3'b001,
        PC_JAL    = 3'b010,
        PC_JALR   = 3'b011,
        PC_RET    = 3'b100
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Next-PC target mux/adder and alignment flag. RET uses the saved epc only when PC_TRAP_EN is
// defined; otherwise it falls back to sequential flow.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned INC    = 4
) (
    input  logic [DWIDTH-1:0] pc_i,
    input  logic [2:0]        pc_select_i,
    input  logic              comparator_i,
    input  logic [DWIDTH-1:0] immgen_i,
    input  logic [DWIDTH-1:0] alu_i,
    input  logic [DWIDTH-1:0] epc_i,
    output logic [DWIDTH-1:0] target_o,
    output logic              misalign_o
);

    logic [DWIDTH-1:0] seq_target;
    logic [DWIDTH-1:0] rel_target;

    assign seq_target = pc_i + DWIDTH'(INC);
    assign rel_target = pc_i + immgen_i;

    always_comb begin
        target_o = seq_target;
        case (pc_select_i)
            PC_BRANCH: target_o = comparator_i ? rel_target : seq_target;
            PC_JAL:    target_o = rel_target;
            PC_JALR:   target_o = {alu_i[DWIDTH-1:1], 1'b0};
`ifdef PC_TRAP_EN
            PC_RET:    target_o = epc_i;
`endif
            default:   target_o = seq_target;
        endcase
    end

`ifndef PC_TRAP_EN
    logic unused_epc;
    assign unused_epc = ^epc_i;
`endif

    // Checked after JALR bit0 clearing, so only bit 1 can trip on JALR.
    assign misalign_o = |target_o[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-handshaked PC sequencer (IDLE -> FETCH <-> EXEC). Define PC_TRAP_EN to enable the trap
// input, epc register, RET flow and misalign-to-trap redirect.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned       INC          = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [2:0]        pc_select,
    input  logic              comparator,
    input  logic [DWIDTH-1:0] immgen_in,
    input  logic [DWIDTH-1:0] alu_in,
    input  logic              trap,
    input  logic [DWIDTH-1:0] trap_vector,
    input  logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DWIDTH-1:0] pc_value,
    output logic [DWIDTH-1:0] link_value,
    output logic [DWIDTH-1:0] epc_value,
    output logic              misalign
);

    pc_state_e         state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [DWIDTH-1:0] epc_cur;
    logic [DWIDTH-1:0] tgt;
    logic              tgt_misalign;

`ifdef PC_TRAP_EN
    logic [DWIDTH-1:0] epc_q, epc_d;
    assign epc_cur = epc_q;
`else
    logic unused_trap;
    assign unused_trap = trap ^ (^trap_vector);
    assign epc_cur     = '0;
`endif

    pc_target_calc #(
        .DWIDTH(DWIDTH),
        .INC   (INC)
    ) u_target_calc (
        .pc_i        (pc_q),
        .pc_select_i (pc_select),
        .comparator_i(comparator),
        .immgen_i    (immgen_in),
        .alu_i       (alu_in),
        .epc_i       (epc_cur),
        .target_o    (tgt),
        .misalign_o  (tgt_misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
`ifdef PC_TRAP_EN
        epc_d      = epc_q;
`endif
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
`ifdef PC_TRAP_EN
                if (trap) begin
                    epc_d   = pc_q;
                    pc_d    = trap_vector;
                    state_d = ST_FETCH;
                end else
`endif
                if (fetch_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef PC_TRAP_EN
                if (trap) begin
                    epc_d   = pc_q;
                    pc_d    = trap_vector;
                    state_d = ST_FETCH;
                end else
`endif
                if (pc_en) begin
                    if (tgt_misalign) begin
                        misalign_d = 1'b1;
`ifdef PC_TRAP_EN
                        epc_d      = pc_q;
                        pc_d       = trap_vector;
                        state_d    = ST_FETCH;
`endif
                    end else begin
                        pc_d    = tgt;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end
`endif

    assign fetch_valid = (state_q == ST_FETCH);
    assign pc_value    = pc_q;
    assign link_value  = pc_q + DWIDTH'(INC);
    assign epc_value   = epc_cur;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; covers both PC_TRAP_EN builds.
module tb_pc_sequencer;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [2:0]  pc_select;
    logic        comparator;
    logic [31:0] immgen_in;
    logic [31:0] alu_in;
    logic        trap;
    logic [31:0] trap_vector;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc_value;
    logic [31:0] link_value;
    logic [31:0] epc_value;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .pc_en      (pc_en),
        .pc_select  (pc_select),
        .comparator (comparator),
        .immgen_in  (immgen_in),
        .alu_in     (alu_in),
        .trap       (trap),
        .trap_vector(trap_vector),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .pc_value   (pc_value),
        .link_value (link_value),
        .epc_value  (epc_value),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From EXEC: request one advance, land in FETCH with the new PC.
    task automatic exec_op(input logic [2:0] sel);
        pc_select = sel;
        pc_en     = 1'b1;
        step();
        pc_en     = 1'b0;
    endtask

    // From FETCH: complete the handshake, land in EXEC.
    task automatic to_exec();
        fetch_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_en = 1'b0; pc_select = PC_SEQ; comparator = 1'b0;
        immgen_in = '0; alu_in = '0; trap = 1'b0; trap_vector = 32'h80; fetch_ready = 1'b0;
        step();
        step();
        checks++; if (pc_value !== 32'h0) begin errors++;
            $display("FAIL reset_pc: got %h expected %h", pc_value, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++;
            $display("FAIL reset_fv: got %b expected 0", fetch_valid); end
        checks++; if (misalign !== 1'b0) begin errors++;
            $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (epc_value !== 32'h0) begin errors++;
            $display("FAIL reset_epc: got %h expected 0", epc_value); end
        reset = 1'b0;
    endtask

    task automatic test_seq();
        logic [7:0]  exp_fv;
        logic [31:0] exp_pc [8];
        exp_fv = 8'b1010_1010; // bit i = sample i
        exp_pc = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC};
        fetch_ready = 1'b1; pc_en = 1'b1; pc_select = PC_SEQ;
        for (int i = 0; i < 8; i++) begin
            checks++; if (fetch_valid !== exp_fv[i]) begin errors++;
                $display("FAIL seq_fv[%0d]: got %b expected %b", i, fetch_valid, exp_fv[i]); end
            checks++; if (pc_value !== exp_pc[i]) begin errors++;
                $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_value, exp_pc[i]); end
            if (i == 7) pc_en = 1'b0;
            step();
        end
        // Now EXEC at 0xC.
    endtask

    task automatic test_branch();
        exec_op(PC_SEQ);
        to_exec();
        immgen_in = 32'hFFFF_FFF8; comparator = 1'b1;
        exec_op(PC_BRANCH);
        checks++; if (pc_value !== 32'h8 || fetch_valid !== 1'b1) begin errors++;
            $display("FAIL branch_taken: got pc %h fv %b expected 8 1", pc_value, fetch_valid); end
        to_exec(); exec_op(PC_SEQ); to_exec(); exec_op(PC_SEQ); to_exec();
        comparator = 1'b0;
        exec_op(PC_BRANCH);
        checks++; if (pc_value !== 32'h14) begin errors++;
            $display("FAIL branch_not_taken: got %h expected 14", pc_value); end
        to_exec();
    endtask

    task automatic test_jump_misalign();
        alu_in = 32'h0000_0101;
        exec_op(PC_JALR);
        checks++; if (pc_value !== 32'h100 || misalign !== 1'b0) begin errors++;
            $display("FAIL jalr: got pc %h mis %b expected 100 0", pc_value, misalign); end
        to_exec();
        immgen_in = 32'h2;
        exec_op(PC_JAL);
        checks++; if (misalign !== 1'b1) begin errors++;
            $display("FAIL jal_misalign_pulse: got %b expected 1", misalign); end
`ifdef PC_TRAP_EN
        checks++; if (pc_value !== 32'h80 || epc_value !== 32'h100 || fetch_valid !== 1'b1)
            begin errors++;
            $display("FAIL jal_misalign_trap: got pc %h epc %h fv %b expected 80 100 1",
                     pc_value, epc_value, fetch_valid); end
`else
        checks++; if (pc_value !== 32'h100 || fetch_valid !== 1'b0) begin errors++;
            $display("FAIL jal_misalign_hold: got pc %h fv %b expected 100 0",
                     pc_value, fetch_valid); end
`endif
        fetch_ready = 1'b1;
        step();
        checks++; if (misalign !== 1'b0) begin errors++;
            $display("FAIL misalign_clear: got %b expected 0", misalign); end
        // EXEC at 0x80 (trap build) or 0x100 (default build).
    endtask

    task automatic test_trap_ret();
`ifdef PC_TRAP_EN
        alu_in = 32'h20;
        exec_op(PC_JALR);
        to_exec();
        trap = 1'b1; trap_vector = 32'h80; pc_en = 1'b1; pc_select = PC_SEQ;
        step();
        trap = 1'b0; pc_en = 1'b0;
        checks++; if (pc_value !== 32'h80 || epc_value !== 32'h20) begin errors++;
            $display("FAIL trap_redirect: got pc %h epc %h expected 80 20", pc_value, epc_value); end
        to_exec();
        exec_op(PC_RET);
        checks++; if (pc_value !== 32'h20) begin errors++;
            $display("FAIL ret: got %h expected 20", pc_value); end
        to_exec();
`else
        trap = 1'b1; trap_vector = 32'h80;
        exec_op(PC_SEQ);
        trap = 1'b0;
        checks++; if (pc_value !== 32'h104 || epc_value !== 32'h0) begin errors++;
            $display("FAIL trap_ignored: got pc %h epc %h expected 104 0", pc_value, epc_value); end
        to_exec();
        exec_op(PC_RET);
        checks++; if (pc_value !== 32'h108) begin errors++;
            $display("FAIL ret_as_seq: got %h expected 108", pc_value); end
        to_exec();
`endif
    endtask

    task automatic test_stall_reset();
        logic [31:0] hold_pc;
`ifdef PC_TRAP_EN
        hold_pc = 32'h24;
`else
        hold_pc = 32'h10C;
`endif
        exec_op(PC_SEQ);
        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc_en = i[0];
            step();
            checks++; if (pc_value !== hold_pc || fetch_valid !== 1'b1) begin errors++;
                $display("FAIL stall[%0d]: got pc %h fv %b expected %h 1",
                         i, pc_value, fetch_valid, hold_pc); end
        end
        pc_en = 1'b0; reset = 1'b1; fetch_ready = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (pc_value !== 32'h0 || fetch_valid !== 1'b0 || epc_value !== 32'h0)
            begin errors++;
            $display("FAIL stall_reset: got pc %h fv %b epc %h expected 0 0 0",
                     pc_value, fetch_valid, epc_value); end
        step();
        checks++; if (fetch_valid !== 1'b1) begin errors++;
            $display("FAIL post_reset_fetch: got %b expected 1", fetch_valid); end
    endtask

    task automatic test_wrap();
        to_exec();
        alu_in = 32'hFFFF_FFFC;
        exec_op(PC_JALR);
        to_exec();
        checks++; if (pc_value !== 32'hFFFF_FFFC || link_value !== 32'h0) begin errors++;
            $display("FAIL wrap_link: got pc %h link %h expected fffffffc 0",
                     pc_value, link_value); end
        exec_op(PC_SEQ);
        checks++; if (pc_value !== 32'h0 || misalign !== 1'b0) begin errors++;
            $display("FAIL wrap_pc: got pc %h mis %b expected 0 0", pc_value, misalign); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump_misalign();
        test_trap_ret();
        test_stall_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
